// File: rtl/rv_pkg.sv
// Shared RISC-V definitions: load/store funct3 encodings and the LSU state type.
package rv_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RESP
  } lsu_state_t;

endpackage

// File: rtl/lsu_load_align.sv
// Picks the addressed byte/halfword lane out of a read word and sign- or zero-extends it.
module lsu_load_align
  import rv_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    lane_b = word[7:0];
    case (offset)
      2'd0: lane_b = word[7:0];
      2'd1: lane_b = word[15:8];
      2'd2: lane_b = word[23:16];
      2'd3: lane_b = word[31:24];
      default: lane_b = word[7:0];
    endcase
    lane_h = offset[1] ? word[31:16] : word[15:0];

    case (funct3)
      F3_B:    result = {{24{lane_b[7]}}, lane_b};
      F3_H:    result = {{16{lane_h[15]}}, lane_h};
      F3_BU:   result = {24'd0, lane_b};
      F3_HU:   result = {16'd0, lane_h};
      default: result = word;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: one data-memory transaction per accepted instruction, with
// lane alignment, store strobes, load extension, fault detection and timeout.
module lsu
  import rv_pkg::*;
#(
  parameter int D_WIDTH = 32,
  parameter int TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ex_valid,
  input  logic               ex_mem_read,
  input  logic               ex_mem_write,
  input  logic [2:0]         ex_funct3,
  input  logic [D_WIDTH-1:0] ex_addr,
  input  logic [D_WIDTH-1:0] ex_wdata,
  output logic               lsu_busy,
  output logic               wb_valid,
  output logic [D_WIDTH-1:0] wb_rdata,
  output logic               wb_fault,
  output logic               dmem_req,
  output logic               dmem_we,
  output logic [D_WIDTH-1:0] dmem_addr,
  output logic [3:0]         dmem_wstrb,
  output logic [D_WIDTH-1:0] dmem_wdata,
  input  logic               dmem_ready,
  input  logic [D_WIDTH-1:0] dmem_rdata
);

  lsu_state_t state, next_state;

  logic [7:0]  cnt;
  logic [2:0]  req_f3;
  logic [1:0]  req_off;
  logic [31:0] ld_result;
  logic [3:0]  st_strb;
  logic [31:0] st_wdata;
  logic        accept;
  logic        fault;
  logic        timeout;

  assign accept  = (state == IDLE) && ex_valid && (ex_mem_read || ex_mem_write);
  assign timeout = (state == REQ) && !dmem_ready && (cnt == 8'(TIMEOUT - 1));

  always_comb begin
    fault = 1'b0;
    if (ex_mem_read && ex_mem_write)
      fault = 1'b1;
    if ((ex_funct3 == 3'b011) || (ex_funct3[2:1] == 2'b11))
      fault = 1'b1;
    if ((ex_funct3[1:0] == 2'b01) && ex_addr[0])
      fault = 1'b1;
    if ((ex_funct3[1:0] == 2'b10) && (ex_addr[1:0] != 2'b00))
      fault = 1'b1;
  end

  // Narrow stores replicate their data across lanes so memory only needs the strobes.
  always_comb begin
    st_strb  = 4'b1111;
    st_wdata = ex_wdata;
    case (ex_funct3[1:0])
      2'b00: begin
        st_wdata = {4{ex_wdata[7:0]}};
        st_strb  = 4'b0001 << ex_addr[1:0];
      end
      2'b01: begin
        st_wdata = {2{ex_wdata[15:0]}};
        st_strb  = ex_addr[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        st_wdata = ex_wdata;
        st_strb  = 4'b1111;
      end
    endcase
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept) next_state = fault ? RESP : REQ;
      REQ:     if (dmem_ready || timeout) next_state = RESP;
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= next_state;
  end

  lsu_load_align u_load_align (
    .word   (dmem_rdata),
    .offset (req_off),
    .funct3 (req_f3),
    .result (ld_result)
  );

  // Request fields are frozen at accept; write-back fields change only on completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= 8'd0;
      req_f3     <= 3'd0;
      req_off    <= 2'd0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wstrb <= 4'd0;
      dmem_wdata <= '0;
      wb_rdata   <= '0;
      wb_fault   <= 1'b0;
    end else begin
      if (accept) begin
        cnt        <= 8'd0;
        req_f3     <= ex_funct3;
        req_off    <= ex_addr[1:0];
        dmem_we    <= ex_mem_write;
        dmem_addr  <= {ex_addr[31:2], 2'b00};
        dmem_wstrb <= ex_mem_write ? st_strb : 4'b0000;
        dmem_wdata <= ex_mem_write ? st_wdata : 32'd0;
        if (fault) begin
          wb_rdata <= '0;
          wb_fault <= 1'b1;
        end
      end
      if (state == REQ) begin
        cnt <= cnt + 8'd1;
        if (dmem_ready) begin
          wb_rdata <= dmem_we ? 32'd0 : ld_result;
          wb_fault <= 1'b0;
        end else if (timeout) begin
          wb_rdata <= '0;
          wb_fault <= 1'b1;
        end
      end
    end
  end

  assign lsu_busy = (state != IDLE);
  assign wb_valid = (state == RESP);
  assign dmem_req = (state == REQ);

endmodule

// File: tb/tb_lsu.sv
// Randomized bench for the LSU: a transaction-level model predicts every cycle's outputs.
module tb_lsu;
  import rv_pkg::*;

  localparam int TIMEOUT = 255;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid, ex_mem_read, ex_mem_write;
  logic [2:0]  ex_funct3;
  logic [31:0] ex_addr, ex_wdata;
  logic        lsu_busy, wb_valid, wb_fault;
  logic [31:0] wb_rdata;
  logic        dmem_req, dmem_we, dmem_ready;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_wstrb;

  int checks = 0;
  int failures = 0;

  logic        chk_en = 1'b0;
  logic        exp_busy, exp_req, exp_wbv, exp_we;
  logic [31:0] exp_addr, exp_wdata;
  logic [3:0]  exp_strb;
  logic [31:0] hold_rdata = 32'd0;
  logic        hold_fault = 1'b0;

  always #5 clk = ~clk;

  lsu #(.D_WIDTH(32), .TIMEOUT(TIMEOUT)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ex_valid     (ex_valid),
    .ex_mem_read  (ex_mem_read),
    .ex_mem_write (ex_mem_write),
    .ex_funct3    (ex_funct3),
    .ex_addr      (ex_addr),
    .ex_wdata     (ex_wdata),
    .lsu_busy     (lsu_busy),
    .wb_valid     (wb_valid),
    .wb_rdata     (wb_rdata),
    .wb_fault     (wb_fault),
    .dmem_req     (dmem_req),
    .dmem_we      (dmem_we),
    .dmem_addr    (dmem_addr),
    .dmem_wstrb   (dmem_wstrb),
    .dmem_wdata   (dmem_wdata),
    .dmem_ready   (dmem_ready),
    .dmem_rdata   (dmem_rdata)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int accessSize(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic logic modelFault(input logic rd, input logic wr, input logic [2:0] f3,
                                      input logic [31:0] addr);
    if (rd && wr) return 1'b1;
    if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) return 1'b1;
    return (addr % accessSize(f3)) != 0;
  endfunction

  function automatic logic [3:0] modelStrb(input logic [2:0] f3, input logic [31:0] addr);
    int mask;
    mask = ((1 << accessSize(f3)) - 1) << (addr % 4);
    return 4'(mask);
  endfunction

  function automatic logic [31:0] modelWdata(input logic [2:0] f3, input logic [31:0] data);
    logic [31:0] r;
    int sz;
    sz = accessSize(f3);
    r = 32'd0;
    for (int i = 0; i < 4; i++)
      r[8*i +: 8] = data[8*(i % sz) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] modelLoad(input logic [31:0] word, input logic [1:0] off,
                                            input logic [2:0] f3);
    logic [31:0] w;
    logic signed [7:0] sb;
    logic signed [15:0] sh;
    int v;
    w = word >> (int'(off) * 8);
    if (f3[1:0] == 2'b01) w = word >> (int'(off[1]) * 16);
    sb = w[7:0];
    sh = w[15:0];
    case (f3)
      F3_B:  begin v = sb; return v; end
      F3_H:  begin v = sh; return v; end
      F3_BU: return {24'd0, w[7:0]};
      F3_HU: return {16'd0, w[15:0]};
      default: return word;
    endcase
  endfunction

  // Busy-cycle inputs are random noise the DUT must ignore.
  task automatic driveNoise;
    ex_valid     = 1'($urandom);
    ex_mem_read  = 1'($urandom);
    ex_mem_write = 1'($urandom);
    ex_funct3    = 3'($urandom);
    ex_addr      = $urandom;
    ex_wdata     = $urandom;
  endtask

  task automatic setIdle;
    exp_busy = 1'b0; exp_req = 1'b0; exp_wbv = 1'b0;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      checkOutput("lsu_busy", 32'(lsu_busy), 32'(exp_busy));
      checkOutput("dmem_req", 32'(dmem_req), 32'(exp_req));
      checkOutput("wb_valid", 32'(wb_valid), 32'(exp_wbv));
      checkOutput("wb_rdata", wb_rdata, hold_rdata);
      checkOutput("wb_fault", 32'(wb_fault), 32'(hold_fault));
      if (exp_req) begin
        checkOutput("dmem_we", 32'(dmem_we), 32'(exp_we));
        checkOutput("dmem_addr", dmem_addr, exp_addr);
        checkOutput("dmem_wstrb", 32'(dmem_wstrb), 32'(exp_strb));
        if (exp_we) checkOutput("dmem_wdata", dmem_wdata, exp_wdata);
      end
    end
  end

  // Entered and left at posedge+1 of an idle cycle; lat = REQ cycle in which memory answers.
  task automatic applyStimulus(input logic rd, input logic wr, input logic [2:0] f3,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [31:0] rdata, input int lat);
    logic flt, tmo;
    int nreq;
    ex_valid = 1'b1; ex_mem_read = rd; ex_mem_write = wr;
    ex_funct3 = f3; ex_addr = addr; ex_wdata = wdata;
    dmem_ready = 1'($urandom); dmem_rdata = $urandom;
    setIdle();
    @(posedge clk); #1;
    if (!rd && !wr) begin
      ex_valid = 1'b0;
      return;
    end
    driveNoise();
    flt = modelFault(rd, wr, f3, addr);
    tmo = (lat > TIMEOUT);
    if (!flt) begin
      nreq = tmo ? TIMEOUT : lat;
      for (int i = 1; i <= nreq; i++) begin
        exp_busy = 1'b1; exp_req = 1'b1; exp_wbv = 1'b0;
        exp_we = wr; exp_addr = {addr[31:2], 2'b00};
        exp_strb = wr ? modelStrb(f3, addr) : 4'b0000;
        exp_wdata = modelWdata(f3, wdata);
        dmem_ready = (i == lat);
        dmem_rdata = (i == lat) ? rdata : $urandom;
        @(posedge clk); #1;
        driveNoise();
      end
    end
    exp_busy = 1'b1; exp_req = 1'b0; exp_wbv = 1'b1;
    if (flt || tmo) begin
      hold_rdata = 32'd0; hold_fault = 1'b1;
    end else begin
      hold_rdata = wr ? 32'd0 : modelLoad(rdata, addr[1:0], f3);
      hold_fault = 1'b0;
    end
    dmem_ready = 1'($urandom); dmem_rdata = $urandom;
    @(posedge clk); #1;
    ex_valid = 1'b0;
    setIdle();
  endtask

  task automatic resetMidReq;
    ex_valid = 1'b1; ex_mem_read = 1'b1; ex_mem_write = 1'b0;
    ex_funct3 = F3_W; ex_addr = 32'h300; dmem_ready = 1'b0;
    setIdle();
    @(posedge clk); #1;
    driveNoise();
    exp_busy = 1'b1; exp_req = 1'b1; exp_wbv = 1'b0; exp_we = 1'b0;
    exp_addr = 32'h300; exp_strb = 4'b0000;
    @(posedge clk); #1;
    #2;
    chk_en = 1'b0;
    rst_n = 1'b0;
    #1;
    checkOutput("rst_dmem_req", 32'(dmem_req), 32'd0);
    checkOutput("rst_lsu_busy", 32'(lsu_busy), 32'd0);
    checkOutput("rst_wb_valid", 32'(wb_valid), 32'd0);
    hold_rdata = 32'd0; hold_fault = 1'b0;
    @(posedge clk); #1;
    checkOutput("rst_wb_valid_hold", 32'(wb_valid), 32'd0);
    rst_n = 1'b1;
    ex_valid = 1'b0;
    setIdle();
    chk_en = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    logic [2:0] f3;
    logic rd, wr;
    int sel;
    rst_n = 1'b0;
    ex_valid = 1'b0; ex_mem_read = 1'b0; ex_mem_write = 1'b0;
    ex_funct3 = 3'd0; ex_addr = 32'd0; ex_wdata = 32'd0;
    dmem_ready = 1'b0; dmem_rdata = 32'd0;
    setIdle();
    exp_we = 1'b0; exp_addr = 32'd0; exp_strb = 4'd0; exp_wdata = 32'd0;

    #12;
    checkOutput("reset_busy", 32'(lsu_busy), 32'd0);
    checkOutput("reset_req", 32'(dmem_req), 32'd0);
    checkOutput("reset_wbv", 32'(wb_valid), 32'd0);
    checkOutput("reset_rdata", wb_rdata, 32'd0);
    checkOutput("reset_strb", 32'(dmem_wstrb), 32'd0);

    // Hand-computed values that pin the reference model itself.
    checkOutput("model_lb", modelLoad(32'h80123456, 2'd3, F3_B), 32'hFFFFFF80);
    checkOutput("model_lhu", modelLoad(32'h80123456, 2'd2, F3_HU), 32'h00008012);
    checkOutput("model_sb_strb", 32'(modelStrb(F3_B, 32'h201)), 32'h2);
    checkOutput("model_sh_wdata", modelWdata(F3_H, 32'h00001234), 32'h12341234);
    checkOutput("model_lw_fault", 32'(modelFault(1'b1, 1'b0, F3_W, 32'h102)), 32'd1);

    @(posedge clk); #1;
    rst_n = 1'b1;
    chk_en = 1'b1;
    @(posedge clk); #1;

    applyStimulus(1, 0, F3_W, 32'h100, 32'd0, 32'hDEADBEEF, 1);
    checkOutput("lw_rdata", wb_rdata, 32'hDEADBEEF);
    applyStimulus(1, 0, F3_B, 32'h103, 32'd0, 32'h80123456, 1);
    checkOutput("lb_rdata", wb_rdata, 32'hFFFFFF80);
    applyStimulus(1, 0, F3_BU, 32'h103, 32'd0, 32'h80123456, 2);
    checkOutput("lbu_rdata", wb_rdata, 32'h00000080);
    applyStimulus(1, 0, F3_HU, 32'h102, 32'd0, 32'h80123456, 1);
    checkOutput("lhu_rdata", wb_rdata, 32'h00008012);
    applyStimulus(0, 1, F3_B, 32'h201, 32'h000000AB, 32'hFFFFFFFF, 1);
    checkOutput("sb_rdata", wb_rdata, 32'd0);
    applyStimulus(0, 1, F3_H, 32'h202, 32'h00001234, 32'd0, 2);
    applyStimulus(1, 0, F3_W, 32'h102, 32'd0, 32'd0, 1);
    checkOutput("misaligned_fault", 32'(wb_fault), 32'd1);
    applyStimulus(1, 1, F3_W, 32'h104, 32'd0, 32'd0, 1);
    checkOutput("rw_fault", 32'(wb_fault), 32'd1);
    applyStimulus(1, 0, F3_W, 32'h108, 32'd0, 32'h12345678, 3);
    checkOutput("wait3_fault", 32'(wb_fault), 32'd0);
    applyStimulus(1, 0, F3_W, 32'h10C, 32'd0, 32'h0, TIMEOUT + 10);
    checkOutput("timeout_fault", 32'(wb_fault), 32'd1);
    applyStimulus(1, 0, F3_W, 32'h110, 32'd0, 32'hCAFEF00D, TIMEOUT);
    checkOutput("last_cycle_ready", wb_rdata, 32'hCAFEF00D);
    resetMidReq();
    applyStimulus(1, 0, F3_W, 32'h100, 32'd0, 32'h0BADF00D, 1);
    checkOutput("post_reset_lw", wb_rdata, 32'h0BADF00D);

    for (int n = 0; n < 250; n++) begin
      sel = $urandom_range(0, 19);
      rd = (sel < 9) || (sel == 18);
      wr = (sel >= 9 && sel < 18) || (sel == 18);
      if ($urandom_range(0, 4) == 0) f3 = 3'($urandom);
      else begin
        case ($urandom_range(0, 4))
          0: f3 = F3_B;
          1: f3 = F3_H;
          2: f3 = F3_W;
          3: f3 = F3_BU;
          default: f3 = F3_HU;
        endcase
      end
      applyStimulus(rd, wr, f3, $urandom, $urandom, $urandom, $urandom_range(1, 6));
      repeat ($urandom_range(0, 2)) begin
        dmem_ready = 1'($urandom);
        @(posedge clk); #1;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lsu.md
Name: lsu

Overview:
- Load/store unit sitting directly downstream of the execute-stage ALU.
- Takes the ALU result as the effective address and rs2 as store data.
- Performs one data-memory transaction over a ready-handshake bus with variable latency, including byte-lane alignment, store strobes, load sign/zero extension and fault detection.
- Stalls the pipeline while busy and returns a one-cycle write-back pulse.

Parameters:
- D_WIDTH, 32, data/address width; only 32 supported (byte-lane logic fixed to 4 lanes).
- TIMEOUT, 255, max cycles waiting for dmem_ready before abort with fault; 8-bit counter.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- ex_valid  input  1  execute stage presents an instruction this cycle.
- ex_mem_read  input  1  instruction is a load.
- ex_mem_write  input  1  instruction is a store.
- ex_funct3  input  3  size/sign: 000 b, 001 h, 010 w, 100 bu, 101 hu.
- ex_addr  input  D_WIDTH  effective address (ALU output).
- ex_wdata  input  D_WIDTH  store data (rs2).
- lsu_busy  output  1  stall request to upstream.
- wb_valid  output  1  one-cycle completion pulse.
- wb_rdata  output  D_WIDTH  extended load data; 0 for stores and faults.
- wb_fault  output  1  misaligned, illegal funct3, read+write both set, or timeout; valid with wb_valid.
- dmem_req  output  1  memory request.
- dmem_we  output  1  write enable.
- dmem_addr  output  D_WIDTH  word-aligned address {addr[31:2],2'b00}.
- dmem_wstrb  output  4  byte strobes.
- dmem_wdata  output  D_WIDTH  lane-replicated store data.
- dmem_ready  input  1  memory completes the transaction this cycle.
- dmem_rdata  input  D_WIDTH  read word, valid when dmem_ready.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values: state IDLE; all outputs 0; timeout counter 0.
- States: IDLE, REQ, RESP.
- IDLE: accept when ex_valid && (ex_mem_read || ex_mem_write). Register addr, funct3, we, formatted wdata/strb and the fault decision.
  - Fault at accept → RESP.
  - Otherwise → REQ.
  - No accept → stay.
- Fault conditions:
  - h/hu with addr[0]=1.
  - w with addr[1:0]≠0.
  - funct3 ∈ {011,110,111}.
  - read and write both set.
  - A faulting access never asserts dmem_req.
- REQ: dmem_req=1. dmem_we, dmem_addr, dmem_wstrb and dmem_wdata stay constant until dmem_ready.
  - dmem_ready=1: capture aligned load result → RESP.
  - Counter increments each REQ cycle. Reaching TIMEOUT without ready → RESP with fault, request dropped.
- RESP: wb_valid=1 for exactly one cycle, then → IDLE. wb_rdata/wb_fault registered, held until next completion overwrites.
- lsu_busy = (state≠IDLE), combinational. No new accept in REQ or RESP.
- Latency:
  - Accept cycle T, memory ready in T+1 → wb_valid at T+2.
  - Fault → wb_valid at T+1.
  - Minimum issue interval 3 cycles.
- Store formatting:
  - sb: wdata byte replicated to all 4 lanes; wstrb = 0001<<addr[1:0].
  - sh: halfword replicated ×2; wstrb 0011 (addr[1]=0) or 1100.
  - sw: wstrb 1111.
  - Loads drive wstrb 0000 and we 0.
- Load formatting: select byte lane addr[1:0] or half lane addr[1].
  - b/h sign-extend from bit 7/15.
  - bu/hu zero-extend.
  - w passes through.
- Stores complete with wb_rdata=0, wb_fault=0.
- Reset mid-transaction: immediate return to IDLE; dmem_req falls asynchronously; no wb_valid for the abandoned access. Memory tolerates a dropped request.
- dmem_ready outside REQ is ignored.

Decomposition:
- Shared package rv_pkg: funct3 load/store constants (F3_B, F3_H, F3_W, F3_BU, F3_HU) and the lsu_state_t enum {IDLE, REQ, RESP}.
- One combinational sub-module lsu_load_align (rdata word, addr[1:0], funct3 → extended result). Store formatting stays inline.

Test Plan:
- lw addr 0x100, memory ready 1st REQ cycle, rdata 0xDEADBEEF → wb_valid at T+2, wb_rdata 0xDEADBEEF, fault 0.
- lb addr 0x103, rdata 0x80123456 → wb_rdata 0xFFFFFF80; lbu same → 0x00000080; lhu addr 0x102 → 0x00008012.
- sb addr 0x201, wdata 0x000000AB → dmem_wstrb 0010, dmem_wdata 0xABABABAB, dmem_addr 0x200; sh addr 0x202 data 0x1234 → wstrb 1100, wdata 0x12341234.
- lw addr 0x102 → no dmem_req, wb_valid at T+1 with wb_fault 1; read+write both set → same.
- dmem_ready held low → dmem_req stable for TIMEOUT cycles, then wb_fault 1. A 3-cycle wait variant completes normally, lsu_busy high throughout.
- rst_n low during REQ → dmem_req and lsu_busy 0 immediately, no wb_valid; next lw after release completes normally.
